// File: rtl/bit_serial_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding and default operand width.
package bit_serial_pkg;

   localparam int DEFAULT_N = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder.
// The single arithmetic cell reused every cycle by the serial adder.
module fa_cell (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic Sum,
   output logic Carry
);

   // Sum and carry of three input bits
   always_comb begin
      Sum   = A ^ B ^ C;
      Carry = (A & B) | (C & (A | B));
   end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, LSB-first.
// Optional macro OVERFLOW_FLAG_EN adds the signed overflow output ovf.
module bit_serial_adder
   import bit_serial_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic         ovf
`endif
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_t           state;
   logic [N-1:0]     a_sr;
   logic [N-1:0]     b_sr;
   logic [N-1:0]     sum_sr;
   logic [N-1:0]     sum_shift;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             cout_r;
   logic             fa_sum;
   logic             fa_carry;
   logic             last;

   fa_cell u_fa (
      .A     (a_sr[0]),
      .B     (b_sr[0]),
      .C     (carry),
      .Sum   (fa_sum),
      .Carry (fa_carry)
   );

   // New sum bit enters at the MSB, older bits move toward the LSB
   generate
      if (N == 1) begin : g_one
         assign sum_shift = fa_sum;
      end else begin : g_many
         assign sum_shift = {fa_sum, sum_sr[N-1:1]};
      end
   endgenerate

   // Final bit is being processed when the counter reaches N-1
   always_comb begin
      last = (cnt == CNT_W'(N - 1));
   end

   // Sequencer: load, shift one bit per clock, then pulse done
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         cout_r <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a_in;
                  b_sr  <= b_in;
                  carry <= cin;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sum_sr <= sum_shift;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               carry  <= fa_carry;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  cout_r <= fa_carry;
                  state  <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef OVERFLOW_FLAG_EN
   logic ovf_r;

   // Overflow: carry into the MSB differs from carry out of it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (state == SHIFT && last) begin
         ovf_r <= carry ^ fa_carry;
      end
   end

   assign ovf = ovf_r;
`endif

   assign busy = (state == SHIFT);
   assign done = (state == DONE);
   assign sum  = sum_sr;
   assign cout = cout_r;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (N=8 and N=1 instances).
// Expected results are queued at start acceptance and popped on done.
module tb_bit_serial_adder;
   import bit_serial_pkg::*;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   typedef struct {
      logic [7:0] s;
      logic       co;
      logic       ov;
   } exp8_t;

   typedef struct {
      logic s;
      logic co;
      logic ov;
   } exp1_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;
   logic       ovf8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;
   logic       ovf1;

   int checks = 0;
   int errors = 0;

   exp8_t sb8[$];
   exp1_t sb1[$];
   vec_t  tbl[8];

   always #5 clk = ~clk;

   bit_serial_adder #(.N(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a_in  (a8),
      .b_in  (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
`ifdef OVERFLOW_FLAG_EN
      ,
      .ovf   (ovf8)
`endif
   );

   bit_serial_adder #(.N(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a_in  (a1),
      .b_in  (b1),
      .cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1)
`ifdef OVERFLOW_FLAG_EN
      ,
      .ovf   (ovf1)
`endif
   );

`ifndef OVERFLOW_FLAG_EN
   assign ovf8 = 1'b0;
   assign ovf1 = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   // Scoreboard for the N=8 instance
   always @(negedge clk) begin
      if (done8) begin
         if (sb8.size() == 0) begin
            chk("spurious_done8", 32'd1, 32'd0);
         end else begin
            exp8_t e;
            e = sb8.pop_front();
            chk("sum8", 32'(sum8), 32'(e.s));
            chk("cout8", 32'(cout8), 32'(e.co));
`ifdef OVERFLOW_FLAG_EN
            chk("ovf8", 32'(ovf8), 32'(e.ov));
`endif
         end
      end
   end

   // Scoreboard for the N=1 instance
   always @(negedge clk) begin
      if (done1) begin
         if (sb1.size() == 0) begin
            chk("spurious_done1", 32'd1, 32'd0);
         end else begin
            exp1_t e;
            e = sb1.pop_front();
            chk("sum1", 32'(sum1), 32'(e.s));
            chk("cout1", 32'(cout1), 32'(e.co));
`ifdef OVERFLOW_FLAG_EN
            chk("ovf1", 32'(ovf1), 32'(e.ov));
`endif
         end
      end
   end

   task automatic add8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es,
                       input logic eco, input logic eov);
      int i;
      int bad;
      @(negedge clk);
      a8 = a;
      b8 = b;
      cin8 = c;
      start8 = 1'b1;
      @(posedge clk);
      sb8.push_back('{s: es, co: eco, ov: eov});
      #1;
      start8 = 1'b0;
      i = 0;
      bad = 0;
      if (!busy8) bad++;
      while (!done8 && i < 40) begin
         @(posedge clk);
         #1;
         i++;
         if (!done8 && !busy8) bad++;
      end
      chk("lat8", 32'(i), 32'd8);
      chk("busy8_run", 32'(bad), 32'd0);
      @(posedge clk);
   endtask

   task automatic add1(input logic a, input logic b, input logic c);
      int i;
      logic [1:0] t;
      t = 2'(a) + 2'(b) + 2'(c);
      @(negedge clk);
      a1 = a;
      b1 = b;
      cin1 = c;
      start1 = 1'b1;
      @(posedge clk);
      sb1.push_back('{s: t[0], co: t[1], ov: c ^ t[1]});
      #1;
      start1 = 1'b0;
      chk("busy1", 32'(busy1), 32'd1);
      i = 0;
      while (!done1 && i < 40) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk("lat1", 32'(i), 32'd1);
      @(posedge clk);
   endtask

   initial begin
      int dn[$];
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [8:0] t;

      tbl[0] = '{8'h3C, 8'h0A, 1'b0, 8'h46, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
      tbl[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_sum", 32'(sum8), 32'd0);
      chk("rst_cout", 32'(cout8), 32'd0);
      chk("rst_state", 32'(dut8.state), 32'(IDLE));
      chk("rst_sum1", 32'(sum1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int v = 0; v < 8; v++) begin
         add8(tbl[v].a, tbl[v].b, tbl[v].c,
              tbl[v].s, tbl[v].co, tbl[v].ov);
      end

      // Random vectors against an arithmetic model
      for (int v = 0; v < 4; v++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         t = 9'(ra) + 9'(rb) + 9'(rc);
         add8(ra, rb, rc, t[7:0], t[8],
              (ra[7] == rb[7]) && (t[7] != ra[7]));
      end

      // Result held while idle
      repeat (3) @(posedge clk);
      #1;
      chk("hold_sum", 32'(sum8), 32'(t[7:0]));

      // Reset mid-operation
      @(negedge clk);
      a8 = 8'hFF;
      b8 = 8'h01;
      cin8 = 1'b0;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_busy", 32'(busy8), 32'd0);
      chk("mid_done", 32'(done8), 32'd0);
      chk("mid_sum", 32'(sum8), 32'd0);
      chk("mid_cout", 32'(cout8), 32'd0);
      chk("mid_state", 32'(dut8.state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);

      // Start pulsed while busy is ignored
      @(negedge clk);
      a8 = 8'h3C;
      b8 = 8'h0A;
      cin8 = 1'b0;
      start8 = 1'b1;
      @(posedge clk);
      sb8.push_back('{s: 8'h46, co: 1'b0, ov: 1'b0});
      dn.delete();
      for (int i = 1; i <= 20; i++) begin
         #1;
         if (i == 1) start8 = 1'b0;
         if (i == 3) begin
            a8 = 8'hF0;
            b8 = 8'hF0;
            start8 = 1'b1;
         end
         if (i == 4) start8 = 1'b0;
         @(posedge clk);
         #1;
         if (done8) dn.push_back(i);
      end
      chk("ign_ndone", 32'(dn.size()), 32'd1);
      if (dn.size() > 0) chk("ign_lat", 32'(dn[0]), 32'd8);

      // Start held high: back-to-back additions
      @(negedge clk);
      a8 = 8'h10;
      b8 = 8'h20;
      cin8 = 1'b1;
      start8 = 1'b1;
      @(posedge clk);
      sb8.push_back('{s: 8'h31, co: 1'b0, ov: 1'b0});
      sb8.push_back('{s: 8'h00, co: 1'b1, ov: 1'b1});
      #1;
      a8 = 8'h80;
      b8 = 8'h80;
      cin8 = 1'b0;
      dn.delete();
      for (int i = 1; i <= 24; i++) begin
         @(posedge clk);
         #1;
         if (i == 10) start8 = 1'b0;
         if (done8) dn.push_back(i);
      end
      chk("b2b_ndone", 32'(dn.size()), 32'd2);
      if (dn.size() == 2) begin
         chk("b2b_first", 32'(dn[0]), 32'd8);
         chk("b2b_second", 32'(dn[1]), 32'd18);
      end

      // N=1 exhaustive truth table
      for (int v = 0; v < 8; v++) begin
         add1(v[2], v[1], v[0]);
      end

      repeat (4) @(posedge clk);
      chk("sb8_drain", 32'(sb8.size()), 32'd0);
      chk("sb1_drain", 32'(sb1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
